// File: rtl/upc_scan_capture_if.sv
// Scanner-side bit line and the decoded item outputs of upc_scan_capture.
// master = scanner/consumer side, slave = the capture block.
interface upc_scan_capture_if #(
  parameter int CNT_W = 8
);
  logic             bit_stb;
  logic             bit_in;
  logic             count_clr;
  logic [2:0]       upc_out;
  logic             mark_out;
  logic             item_valid;
  logic             par_err;
  logic             timeout_err;
  logic             busy;
  logic [CNT_W-1:0] item_count;

  modport master (
    output bit_stb, bit_in, count_clr,
    input  upc_out, mark_out, item_valid, par_err, timeout_err, busy, item_count
  );

  modport slave (
    input  bit_stb, bit_in, count_clr,
    output upc_out, mark_out, item_valid, par_err, timeout_err, busy, item_count
  );
endinterface

// File: rtl/upc_scan_capture.sv
// Serial capture of one scanned item frame: start, u2, u1, u0, mark, odd parity.
// Good frames update the held UPC/mark and a saturating scan counter.
module upc_scan_capture #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  upc_scan_capture_if.slave  bus
);
  localparam int GAP_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state_reg;
  logic [4:0]       shift_reg;
  logic [2:0]       bit_cnt_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [2:0]       upc_reg;
  logic             mark_reg;
  logic             valid_reg;
  logic             par_err_reg;
  logic             timeout_reg;
  logic [CNT_W-1:0] count_reg;
  logic             frame_good;

  // shift_reg holds {u2, u1, u0, mark, parity} once all five bits are in
  assign frame_good = ^shift_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      gap_reg     <= '0;
      upc_reg     <= '0;
      mark_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      par_err_reg <= 1'b0;
      timeout_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      valid_reg   <= 1'b0;
      par_err_reg <= 1'b0;
      timeout_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (bus.bit_stb && bus.bit_in) begin
            state_reg   <= S_SHIFT;
            bit_cnt_reg <= '0;
            gap_reg     <= '0;
          end
        end
        S_SHIFT: begin
          // a strobe arriving on the last allowed gap cycle still counts
          if (bus.bit_stb) begin
            shift_reg   <= {shift_reg[3:0], bus.bit_in};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            gap_reg     <= '0;
            if (bit_cnt_reg == 3'd4) begin
              state_reg <= S_CHECK;
            end
          end else if (gap_reg == GAP_MAX) begin
            state_reg   <= S_IDLE;
            timeout_reg <= 1'b1;
            gap_reg     <= '0;
            bit_cnt_reg <= '0;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
        S_CHECK: begin
          state_reg   <= S_IDLE;
          bit_cnt_reg <= '0;
          if (frame_good) begin
            upc_reg   <= shift_reg[4:2];
            mark_reg  <= shift_reg[1];
            valid_reg <= 1'b1;
          end else begin
            par_err_reg <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase

      // clear wins over a same-cycle good-frame increment
      if (bus.count_clr) begin
        count_reg <= '0;
      end else if (state_reg == S_CHECK && frame_good && count_reg != {CNT_W{1'b1}}) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign bus.upc_out     = upc_reg;
  assign bus.mark_out    = mark_reg;
  assign bus.item_valid  = valid_reg;
  assign bus.par_err     = par_err_reg;
  assign bus.timeout_err = timeout_reg;
  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.item_count  = count_reg;
endmodule

// File: tb/tb_upc_scan_capture.sv
// Scoreboard bench for upc_scan_capture: two instances (CNT_W=8 and CNT_W=2)
// get identical stimulus; a negedge monitor pops expected events and compares.
module tb_upc_scan_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  upc_scan_capture_if #(.CNT_W(8)) bus8();
  upc_scan_capture_if #(.CNT_W(2)) bus2();

  upc_scan_capture #(.TIMEOUT_CYC(16), .CNT_W(8)) dut8 (.clk(clk), .reset_n(rst_n), .bus(bus8));
  upc_scan_capture #(.TIMEOUT_CYC(16), .CNT_W(2)) dut2 (.clk(clk), .reset_n(rst_n), .bus(bus2));

  typedef struct {
    logic [2:0] ev;      // {item_valid, par_err, timeout_err}
    logic [2:0] upc;
    logic       mark;
    logic [7:0] c8;
    logic [1:0] c2;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] m_upc = 3'd0;
  logic       m_mark = 1'b0;
  logic [7:0] m_c8 = 8'd0;
  logic [1:0] m_c2 = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic stb, input logic b, input logic clr);
    @(negedge clk);
    bus8.bit_stb = stb; bus8.bit_in = b; bus8.count_clr = clr;
    bus2.bit_stb = stb; bus2.bit_in = b; bus2.count_clr = clr;
  endtask

  task automatic push(input logic [2:0] ev, input int at);
    exp_t e;
    e.ev = ev; e.upc = m_upc; e.mark = m_mark; e.c8 = m_c8; e.c2 = m_c2; e.cyc = at;
    q.push_back(e);
  endtask

  // bits[5] is the start bit, bits[0] the parity bit; good/upc/mark are hand-computed
  task automatic send_frame(input logic [5:0] bits, input int gap, input logic good,
                            input logic [2:0] upc, input logic mark,
                            input logic stb_in_check, input logic clr_in_check);
    int tpar;
    for (int i = 5; i >= 0; i--) begin
      if (i < 5) repeat (gap) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, bits[i], 1'b0);
      if (i == 4) chk("busy_in_shift", 32'(bus8.busy), 32'd1);
    end
    tpar = cyc;
    if (good) begin
      m_upc = upc; m_mark = mark;
      if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
      if (m_c2 != 2'd3)  m_c2 = m_c2 + 2'd1;
    end
    if (clr_in_check) begin m_c8 = 8'd0; m_c2 = 2'd0; end
    push(good ? 3'b100 : 3'b010, tpar + 2);
    drive(stb_in_check, 1'b1, clr_in_check);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    chk("busy_after_frame", 32'(bus8.busy), 32'd0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge clk) begin
    logic [2:0] ev8, ev2;
    exp_t e;
    if (rst_n) begin
      ev8 = {bus8.item_valid, bus8.par_err, bus8.timeout_err};
      ev2 = {bus2.item_valid, bus2.par_err, bus2.timeout_err};
      if (ev8 != 3'b000 || ev2 != 3'b000) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 32'(ev8 | ev2), 32'd0);
        end else begin
          e = q.pop_front();
          $display("event cyc=%0d ev8=%b ev2=%b upc=%b mark=%b cnt8=%0d cnt2=%0d",
                   cyc, ev8, ev2, bus8.upc_out, bus8.mark_out, bus8.item_count, bus2.item_count);
          chk("event8", 32'(ev8), 32'(e.ev));
          chk("event2", 32'(ev2), 32'(e.ev));
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          chk("upc_out", 32'(bus8.upc_out), 32'(e.upc));
          chk("mark_out", 32'(bus8.mark_out), 32'(e.mark));
          chk("upc_out_w2", 32'(bus2.upc_out), 32'(e.upc));
          chk("item_count8", 32'(bus8.item_count), 32'(e.c8));
          chk("item_count2", 32'(bus2.item_count), 32'(e.c2));
          chk("busy_at_event", 32'(bus8.busy), 32'd0);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_upc"},   32'(bus8.upc_out), 32'd0);
    chk({tag, "_mark"},  32'(bus8.mark_out), 32'd0);
    chk({tag, "_pulses"}, 32'({bus8.item_valid, bus8.par_err, bus8.timeout_err}), 32'd0);
    chk({tag, "_busy"},  32'(bus8.busy), 32'd0);
    chk({tag, "_cnt8"},  32'(bus8.item_count), 32'd0);
    chk({tag, "_cnt2"},  32'(bus2.item_count), 32'd0);
  endtask

  initial begin
    int tl;
    bus8.bit_stb = 1'b0; bus8.bit_in = 1'b0; bus8.count_clr = 1'b0;
    bus2.bit_stb = 1'b0; bus2.bit_in = 1'b0; bus2.count_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0);

    // good frame: upc=101 mark=0
    send_frame(6'b110101, 0, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    // parity error: outputs keep 101/0
    send_frame(6'b101111, 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

    // timeout: start + 2 bits, then silence; pulse after 16 idle cycles
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    tl = cyc;
    push(3'b001, tl + 17);
    repeat (20) drive(1'b0, 1'b0, 1'b0);
    chk("busy_after_timeout", 32'(bus8.busy), 32'd0);

    // good frame after timeout: upc=011 mark=1
    send_frame(6'b101110, 0, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0);
    // 15 idle cycles between strobes: still accepted, upc=100 mark=0
    send_frame(6'b110000, 15, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0);

    // spurious zeros in IDLE are ignored
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
    chk("busy_after_zeros", 32'(bus8.busy), 32'd0);
    send_frame(6'b100111, 0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0);   // CNT_W=2 saturates at 3

    // start strobe during CHECK must be ignored (else a timeout would follow)
    send_frame(6'b111111, 0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b0);
    repeat (20) drive(1'b0, 1'b0, 1'b0);

    // count_clr coincident with a good-frame increment gives 0
    send_frame(6'b101000, 0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    send_frame(6'b111001, 0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0);

    // reset mid-frame after 3 bits
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus8.bit_stb = 1'b0; bus2.bit_stb = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    m_upc = 3'd0; m_mark = 1'b0; m_c8 = 8'd0; m_c2 = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0);

    send_frame(6'b110101, 0, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
